// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the rv32i instruction-fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    REFILL = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] target);
    return |target[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// if_id_reg : IF/ID pipeline register with load, hold and flush controls
// Revision  : 1.0
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [PC_W-1:0] d_pc,
  input  logic [31:0]     d_instr,
  input  logic            d_valid,
  output logic [PC_W-1:0] q_pc,
  output logic [31:0]     q_instr,
  output logic            q_valid
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  if_id_t bundle_q;

  // A flush turns the slot into a bubble but keeps the last PC for debug visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      bundle_q.instr <= NOP_INSTR;
      bundle_q.valid <= 1'b0;
    end else if (load) begin
      bundle_q <= '{pc: d_pc, instr: d_instr, valid: d_valid};
    end
  end

  assign q_pc    = bundle_q.pc;
  assign q_instr = bundle_q.instr;
  assign q_valid = bundle_q.valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC, branch redirect, imem addressing and IF/ID for rv32i
// Revision    : 1.0
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_valid,
  output logic            misalign_err,
  output logic [15:0]     redirect_cnt
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic [PC_W-1:0] target_pc;
  logic            if_load;
  logic            fetch_valid;
  logic [31:0]     fetch_instr;

  // Upper target bits fall outside the instruction address space.
  generate
    if (PC_W < 32) begin : g_unused_target_hi
      logic unused_target_hi;
      assign unused_target_hi = ^BrPC[31:PC_W];
    end
  endgenerate

  assign target_pc = {BrPC[PC_W-1:2], 2'b00};

  // During a stall memory re-reads the in-flight word so it is still there on release.
  assign imem_addr = stall ? req_pc_q : pc_q;

  assign fetch_valid = (state == RUN);
  assign fetch_instr = fetch_valid ? imem_rdata : NOP_INSTR;
  assign if_load     = !stall && !PcSel;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      state        <= BOOT;
      misalign_err <= 1'b0;
      redirect_cnt <= 16'd0;
    end else if (PcSel) begin
      pc_q         <= target_pc;
      req_pc_q     <= pc_q;
      state        <= REFILL;
      redirect_cnt <= sat_inc16(redirect_cnt);
      if (is_misaligned(BrPC)) begin
        misalign_err <= 1'b1;
      end
    end else if (!stall) begin
      pc_q     <= pc_q + PC_W'(4);
      req_pc_q <= pc_q;
      state    <= RUN;
    end
  end

  if_id_reg #(
    .PC_W (PC_W)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (if_load),
    .flush   (PcSel),
    .d_pc    (req_pc_q),
    .d_instr (fetch_instr),
    .d_valid (fetch_valid),
    .q_pc    (if_pc),
    .q_instr (if_instr),
    .q_valid (if_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed and randomized checks of fetch_stage
// Revision       : 1.0
// ============================================================================
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int              PC_W     = 9;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic            PcSel = 1'b0;
  logic [31:0]     BrPC = 32'd0;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = 32'd0;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_valid;
  logic            misalign_err;
  logic [15:0]     redirect_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: next fetch address, the word in flight, and the IF/ID slot.
  logic [PC_W-1:0] m_pc, m_slot_addr, m_out_pc;
  logic            m_slot_valid, m_out_valid, m_err;
  logic [31:0]     m_out_instr;
  int              m_cnt;

  fetch_stage #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .PcSel        (PcSel),
    .BrPC         (BrPC),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return {{(32-PC_W){1'b0}}, a} ^ 32'hA5A50000;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic tick(input logic r, input logic s, input logic p, input logic [31:0] b);
    reset = r; stall = s; PcSel = p; BrPC = b;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_slot_addr = RESET_PC; m_slot_valid = 1'b0;
      m_out_pc = '0; m_out_instr = NOP_INSTR; m_out_valid = 1'b0;
      m_err = 1'b0; m_cnt = 0;
    end else if (p) begin
      m_slot_addr  = m_pc;
      m_slot_valid = 1'b0;
      m_pc         = b[PC_W-1:0] & ~PC_W'(3);
      m_out_valid  = 1'b0;
      m_out_instr  = NOP_INSTR;
      if (b[1:0] != 2'b00) m_err = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end else if (!s) begin
      m_out_pc     = m_slot_addr;
      m_out_valid  = m_slot_valid;
      m_out_instr  = m_slot_valid ? mem_word(m_slot_addr) : NOP_INSTR;
      m_slot_addr  = m_pc;
      m_slot_valid = 1'b1;
      m_pc         = m_pc + PC_W'(4);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    vectors += 4;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    if (if_instr !== NOP_INSTR) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP_INSTR); end
    if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    if ({misalign_err, redirect_cnt} !== 17'd0) begin miscompares++; $display("FAIL reset_status: got %b/%h expected 0/0", misalign_err, redirect_cnt); end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (imem_addr !== PC_W'(4 * c)) begin miscompares++; $display("FAIL stream_addr c%0d: got %h expected %h", c, imem_addr, PC_W'(4 * c)); end
      if (c < 2) begin
        vectors++;
        if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stream_boot_valid c%0d: got %b expected 0", c, if_valid); end
      end else begin
        vectors += 2;
        if (if_valid !== 1'b1 || if_pc !== PC_W'(4 * (c - 2))) begin miscompares++; $display("FAIL stream_pc c%0d: got %h/%b expected %h/1", c, if_pc, if_valid, PC_W'(4 * (c - 2))); end
        if (if_instr !== mem_word(PC_W'(4 * (c - 2)))) begin miscompares++; $display("FAIL stream_instr c%0d: got %h expected %h", c, if_instr, mem_word(PC_W'(4 * (c - 2)))); end
      end
      tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_redirect();
    tick(0, 0, 1, 32'h40);
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_bubble1: got %b expected 0", if_valid); end
    tick(0, 0, 0, 0);
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_bubble2: got %b expected 0", if_valid); end
    tick(0, 0, 0, 0);
    vectors += 3;
    if (if_valid !== 1'b1 || if_pc !== PC_W'(9'h040)) begin miscompares++; $display("FAIL redir_target: got %h/%b expected 040/1", if_pc, if_valid); end
    if (if_instr !== mem_word(PC_W'(9'h040))) begin miscompares++; $display("FAIL redir_instr: got %h expected %h", if_instr, mem_word(PC_W'(9'h040))); end
    if (redirect_cnt !== 16'd1) begin miscompares++; $display("FAIL redir_cnt: got %0d expected 1", redirect_cnt); end
  endtask

  task automatic test_stall();
    tick(1, 0, 0, 0);
    for (int c = 0; c < 5; c++) tick(0, 0, 0, 0);
    for (int c = 5; c < 8; c++) begin
      tick(0, 1, 0, 0);
      vectors += 2;
      if (if_pc !== PC_W'(12) || if_instr !== mem_word(PC_W'(12)) || if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_frozen c%0d: got %h/%h expected %h/%h", c, if_pc, if_instr, PC_W'(12), mem_word(PC_W'(12))); end
      if (imem_addr !== PC_W'(16)) begin miscompares++; $display("FAIL stall_addr c%0d: got %h expected %h", c, imem_addr, PC_W'(16)); end
    end
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 0);
      vectors++;
      if (if_pc !== PC_W'(16 + 4 * k) || if_instr !== mem_word(PC_W'(16 + 4 * k)) || if_valid !== 1'b1) begin miscompares++; $display("FAIL stall_resume k%0d: got %h/%h expected %h", k, if_pc, if_instr, PC_W'(16 + 4 * k)); end
    end
  endtask

  task automatic test_stall_redirect();
    tick(1, 0, 0, 0);
    for (int c = 0; c < 4; c++) tick(0, 0, 0, 0);
    tick(0, 1, 1, 32'h100);
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stredir_flush: got %b expected 0", if_valid); end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    vectors++;
    if (if_pc !== PC_W'(9'h100) || if_valid !== 1'b1) begin miscompares++; $display("FAIL stredir_target: got %h/%b expected 100/1", if_pc, if_valid); end
    tick(0, 1, 1, 32'h200);
    vectors++;
    if (if_valid !== 1'b0) begin miscompares++; $display("FAIL stredir_flush2: got %b expected 0", if_valid); end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    vectors += 2;
    if (if_pc !== PC_W'(0) || if_valid !== 1'b1 || if_instr !== mem_word(PC_W'(0))) begin miscompares++; $display("FAIL stredir_wrap: got %h/%b expected 000/1", if_pc, if_valid); end
    if (redirect_cnt !== 16'd2) begin miscompares++; $display("FAIL stredir_cnt: got %0d expected 2", redirect_cnt); end
  endtask

  task automatic test_misalign();
    tick(0, 0, 1, 32'h22);
    vectors++;
    if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    vectors++;
    if (if_pc !== PC_W'(9'h020) || if_valid !== 1'b1) begin miscompares++; $display("FAIL misalign_target: got %h/%b expected 020/1", if_pc, if_valid); end
    tick(0, 0, 1, 32'h80);
    for (int c = 0; c < 4; c++) tick(0, 0, 0, 0);
    vectors++;
    if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky: got %b expected 1", misalign_err); end
    tick(1, 0, 0, 0);
    vectors++;
    if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_clear: got %b expected 0", misalign_err); end
  endtask

  task automatic test_reset_refill();
    tick(1, 0, 0, 0);
    for (int c = 0; c < 3; c++) tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h40);
    tick(1, 1, 0, 0);
    tick(0, 0, 0, 0);
    vectors += 2;
    if (if_valid !== 1'b0 || redirect_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_refill_state: got %b/%0d expected 0/0", if_valid, redirect_cnt); end
    if (imem_addr !== PC_W'(4)) begin miscompares++; $display("FAIL rst_refill_addr: got %h expected %h", imem_addr, PC_W'(4)); end
  endtask

  task automatic test_random();
    logic r, s, p;
    logic [31:0] b;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      p = ($urandom_range(0, 99) < 15);
      b = $urandom;
      if ($urandom_range(0, 9) < 8) b[1:0] = 2'b00;
      tick(r, s, p, b);
      vectors += 6;
      if (imem_addr !== (stall ? m_slot_addr : m_pc)) begin miscompares++; $display("FAIL rand_addr i%0d: got %h expected %h", i, imem_addr, stall ? m_slot_addr : m_pc); end
      if (if_pc !== m_out_pc) begin miscompares++; $display("FAIL rand_pc i%0d: got %h expected %h", i, if_pc, m_out_pc); end
      if (if_instr !== m_out_instr) begin miscompares++; $display("FAIL rand_instr i%0d: got %h expected %h", i, if_instr, m_out_instr); end
      if (if_valid !== m_out_valid) begin miscompares++; $display("FAIL rand_valid i%0d: got %b expected %b", i, if_valid, m_out_valid); end
      if (misalign_err !== m_err) begin miscompares++; $display("FAIL rand_err i%0d: got %b expected %b", i, misalign_err, m_err); end
      if (redirect_cnt !== 16'(m_cnt)) begin miscompares++; $display("FAIL rand_cnt i%0d: got %0d expected %0d", i, redirect_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_misalign();
    test_reset_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
